keypad_scanner: RTL

- Parametrised, clocked successor to the team's combinational 4x4 keypad decoder.
- Drives keypad rows itself in an active-low walking-zero pattern and samples active-low columns through a 2-flop synchroniser.
- Debounces press and release, then delivers one key event per press over a valid/ready handshake.
- Sits between the keypad pins and the command/UI logic.

---
 rtl/keypad_scanner.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// Row-scanning keypad controller: walking-zero row drive, synchronised column sampling,
// press/release debounce and one valid/ready event per press. Macro KEYPAD_HEX_MAP_EN selects the legacy 4x4 legend.
module keypad_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  parameter int CODE_W   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLS-1:0]   col,
  output logic [ROWS-1:0]   row,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_held,
  output logic              overrun
);

  localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int BW  = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE_P, PRESSED} state_t;

  state_t          state, state_nxt;
  logic [COLS-1:0] col_m, col_s;
  logic [DW-1:0]   dwell;
  logic [RIW-1:0]  row_idx, row_idx_nxt, row_adv;
  logic [CIW-1:0]  col_lat, col_lat_nxt, low_col;
  logic [BW-1:0]   deb_cnt, deb_cnt_nxt;
  logic            sample, any_low, press_ok, release_ok;
  logic [CODE_W-1:0] code_new;

`ifdef KEYPAD_HEX_MAP_EN
  if (ROWS != 4 || COLS != 4) begin : g_hex_bad
    $error("KEYPAD_HEX_MAP_EN needs ROWS=4 and COLS=4");
  end

  function automatic logic [3:0] hex_code(input logic [3:0] idx);
    case (idx)
      4'd0:  return 4'h1;
      4'd1:  return 4'h2;
      4'd2:  return 4'h3;
      4'd3:  return 4'hA;
      4'd4:  return 4'h4;
      4'd5:  return 4'h5;
      4'd6:  return 4'h6;
      4'd7:  return 4'hB;
      4'd8:  return 4'h7;
      4'd9:  return 4'h8;
      4'd10: return 4'h9;
      4'd11: return 4'hC;
      4'd12: return 4'hE;
      4'd13: return 4'h0;
      4'd14: return 4'hF;
      default: return 4'hD;
    endcase
  endfunction

  assign code_new = CODE_W'(hex_code(4'({row_idx, col_lat_nxt})));
`else
  assign code_new = CODE_W'(int'(row_idx) * COLS + int'(col_lat_nxt));
`endif

  assign sample  = (dwell == DW'(SCAN_DIV - 1));
  assign any_low = ~&col_s;
  assign row_adv = (row_idx == RIW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
  assign row     = ~(ROWS'(1) << row_idx);

  // Lowest-index pressed column wins.
  always_comb begin
    low_col = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!col_s[i]) low_col = CIW'(i);
    end
  end

  always_comb begin
    state_nxt   = state;
    row_idx_nxt = row_idx;
    col_lat_nxt = col_lat;
    deb_cnt_nxt = deb_cnt;
    press_ok    = 1'b0;
    release_ok  = 1'b0;
    if (sample) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            col_lat_nxt = low_col;
            if (DEBOUNCE == 1) begin
              press_ok    = 1'b1;
              deb_cnt_nxt = '0;
              state_nxt   = PRESSED;
            end else begin
              deb_cnt_nxt = BW'(1);
              state_nxt   = DEBOUNCE_P;
            end
          end else begin
            row_idx_nxt = row_adv;
          end
        end
        DEBOUNCE_P: begin
          if (any_low && low_col == col_lat) begin
            if (deb_cnt == BW'(DEBOUNCE - 1)) begin
              press_ok    = 1'b1;
              deb_cnt_nxt = '0;
              state_nxt   = PRESSED;
            end else begin
              deb_cnt_nxt = deb_cnt + 1'b1;
            end
          end else begin
            row_idx_nxt = row_adv;
            state_nxt   = SCAN;
          end
        end
        PRESSED: begin
          // Row stays held; only a run of idle samples ends the press.
          if (!any_low) begin
            if (deb_cnt == BW'(DEBOUNCE - 1)) begin
              release_ok  = 1'b1;
              deb_cnt_nxt = '0;
              row_idx_nxt = row_adv;
              state_nxt   = SCAN;
            end else begin
              deb_cnt_nxt = deb_cnt + 1'b1;
            end
          end else begin
            deb_cnt_nxt = '0;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_m     <= '1;
      col_s     <= '1;
      dwell     <= '0;
      state     <= SCAN;
      row_idx   <= '0;
      col_lat   <= '0;
      deb_cnt   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      col_m   <= col;
      col_s   <= col_m;
      dwell   <= sample ? '0 : dwell + 1'b1;
      state   <= state_nxt;
      row_idx <= row_idx_nxt;
      col_lat <= col_lat_nxt;
      deb_cnt <= deb_cnt_nxt;
      overrun <= 1'b0;
      if (press_ok) begin
        key_held <= 1'b1;
        // A same-cycle handshake frees the slot for the new event.
        if (!key_valid || key_ready) begin
          key_code  <= code_new;
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
      if (release_ok) key_held <= 1'b0;
    end
  end

endmodule
